// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle arith/logic ops, 1-bit/cycle shifts and an
// optional shift-add multiplier, with registered result and status flags.
module seq_alu #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [5:0]       opCode,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal,
  output logic             outValid,
  input  logic             outReady
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = SW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [5:0] OP_ADD = 6'd0;
  localparam logic [5:0] OP_SUB = 6'd1;
  localparam logic [5:0] OP_AND = 6'd2;
  localparam logic [5:0] OP_OR  = 6'd3;
  localparam logic [5:0] OP_XOR = 6'd4;
  localparam logic [5:0] OP_SHL = 6'd5;
  localparam logic [5:0] OP_SHR = 6'd6;
  localparam logic [5:0] OP_SRA = 6'd7;
  localparam logic [5:0] OP_MUL = 6'd8;

  logic [1:0]       state, next_state;
  logic [5:0]       op_q;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc_hi, acc_lo, mcand;
  logic [SW-1:0]    shamt;
  logic             accept, is_shift, is_mul, is_illegal, go_exec, last_step, load_res;

  logic [WIDTH:0]   add_w, sub_w, mul_sum;
  logic [WIDTH-1:0] imm_res, step_lo, mul_hi, fin_res;
  logic             imm_c, imm_ov, step_c, fin_c, fin_ov;

  assign shamt      = operand2[SW-1:0];
  assign inReady    = (state == IDLE);
  assign accept     = inReady & inValid;
  assign is_shift   = (opCode == OP_SHL) || (opCode == OP_SHR) || (opCode == OP_SRA);
  assign is_mul     = MUL_EN && (opCode == OP_MUL);
  assign is_illegal = (opCode > OP_MUL) || ((opCode == OP_MUL) && !MUL_EN);
  assign go_exec    = (is_shift && (shamt != '0)) || is_mul;
  assign last_step  = (state == EXEC) && (count == CW'(1));
  assign load_res   = (accept && !go_exec) || last_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (inValid) next_state = go_exec ? EXEC : DONE;
      EXEC:    if (count == CW'(1)) next_state = DONE;
      DONE:    if (outReady) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Ops that finish on the accept edge, plus zero-amount shifts.
  always_comb begin
    add_w   = {1'b0, operand1} + {1'b0, operand2};
    sub_w   = {1'b0, operand1} - {1'b0, operand2};
    imm_res = '0;
    imm_c   = 1'b0;
    imm_ov  = 1'b0;
    case (opCode)
      OP_ADD: begin
        imm_res = add_w[WIDTH-1:0];
        imm_c   = add_w[WIDTH];
        imm_ov  = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                  (add_w[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SUB: begin
        imm_res = sub_w[WIDTH-1:0];
        imm_c   = sub_w[WIDTH];
        imm_ov  = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                  (sub_w[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_AND:                 imm_res = operand1 & operand2;
      OP_OR:                  imm_res = operand1 | operand2;
      OP_XOR:                 imm_res = operand1 ^ operand2;
      OP_SHL, OP_SHR, OP_SRA: imm_res = operand1;
      default:                imm_res = '0;
    endcase
    if (is_illegal) begin
      imm_res = '0;
      imm_c   = 1'b0;
      imm_ov  = 1'b0;
    end
  end

  // One shift bit or one multiply step; the multiplier keeps {acc_hi, acc_lo} as the product.
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    step_lo = acc_lo;
    step_c  = 1'b0;
    case (op_q)
      OP_SHL: begin
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
        step_c  = acc_lo[WIDTH-1];
      end
      OP_SHR: begin
        step_lo = {1'b0, acc_lo[WIDTH-1:1]};
        step_c  = acc_lo[0];
      end
      OP_SRA: begin
        step_lo = {acc_lo[WIDTH-1], acc_lo[WIDTH-1:1]};
        step_c  = acc_lo[0];
      end
      default: begin
        step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        step_c  = |mul_hi;
      end
    endcase
  end

  assign fin_res = (state == EXEC) ? step_lo : imm_res;
  assign fin_c   = (state == EXEC) ? step_c  : imm_c;
  assign fin_ov  = (state == EXEC) ? 1'b0    : imm_ov;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      count    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mcand    <= '0;
      result   <= '0;
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
      outValid <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= opCode;
        mcand  <= operand1;
        acc_hi <= '0;
        if (is_mul) begin
          acc_lo <= operand2;
          count  <= CW'(WIDTH);
        end else begin
          acc_lo <= operand1;
          count  <= CW'(shamt);
        end
      end else if (state == EXEC) begin
        count  <= count - CW'(1);
        acc_lo <= step_lo;
        if (op_q == OP_MUL) acc_hi <= mul_hi;
      end

      if (load_res) begin
        result   <= fin_res;
        zero     <= (fin_res == '0);
        negative <= fin_res[WIDTH-1];
        carry    <= fin_c;
        overflow <= fin_ov;
        illegal  <= (state == IDLE) && is_illegal;
        outValid <= 1'b1;
      end else if ((state == DONE) && outReady) begin
        outValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] operand1, operand2;
  logic [5:0]  opCode;
  logic        inValid, outReady;
  logic        inReady, zero, negative, carry, overflow, illegal, outValid;
  logic [31:0] result;

  logic        inValid2, outReady2;
  logic        inReady2, zero2, negative2, carry2, overflow2, illegal2, outValid2;
  logic [31:0] result2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .operand1(operand1), .operand2(operand2), .opCode(opCode),
    .inValid(inValid), .inReady(inReady), .result(result), .zero(zero), .negative(negative),
    .carry(carry), .overflow(overflow), .illegal(illegal), .outValid(outValid),
    .outReady(outReady)
  );

  seq_alu #(.WIDTH(32), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .operand1(operand1), .operand2(operand2), .opCode(opCode),
    .inValid(inValid2), .inReady(inReady2), .result(result2), .zero(zero2),
    .negative(negative2), .carry(carry2), .overflow(overflow2), .illegal(illegal2),
    .outValid(outValid2), .outReady(outReady2)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: results computed from wide integer arithmetic.
  function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic c, output logic ov,
                                output logic ill, output int lat);
    int unsigned n;
    longint      s;
    logic [63:0] w;
    n   = b % 32;
    res = '0; c = 1'b0; ov = 1'b0; ill = 1'b0; lat = 1;
    case (op)
      6'd0: begin
        w = 64'(a) + 64'(b); res = w[31:0]; c = w[32];
        s = longint'($signed(a)) + longint'($signed(b));
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6'd1: begin
        res = a - b; c = (a < b);
        s = longint'($signed(a)) - longint'($signed(b));
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6'd2: res = a & b;
      6'd3: res = a | b;
      6'd4: res = a ^ b;
      6'd5: begin w = 64'(a) << n; res = w[31:0]; c = w[32]; lat = n + 1; end
      6'd6: begin w = {a, 32'h0} >> n; res = w[63:32]; c = w[31]; lat = n + 1; end
      6'd7: begin
        w = {a, 32'h0} >> n; c = w[31];
        res = 32'($signed(a) >>> n); lat = n + 1;
      end
      6'd8: begin w = 64'(a) * 64'(b); res = w[31:0]; c = (w[63:32] != 0); lat = 33; end
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [31:0] er;
    logic        ec, eov, eill;
    int          elat, lat;
    model(op, a, b, er, ec, eov, eill, elat);
    @(negedge clk);
    opCode = op; operand1 = a; operand2 = b; inValid = 1'b1;
    check_eq("in_ready_before_accept", 64'(inReady), 64'd1);
    @(posedge clk); #1;
    inValid  = 1'b0;
    operand1 = $urandom; operand2 = $urandom; opCode = 6'($urandom);
    lat = 1;
    while (!outValid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq($sformatf("latency op%0d", op), 64'(lat), 64'(elat));
    check_eq($sformatf("result op%0d", op), 64'(result), 64'(er));
    check_eq("zero", 64'(zero), 64'(er == 0));
    check_eq("negative", 64'(negative), 64'(er[31]));
    check_eq("carry", 64'(carry), 64'(ec));
    check_eq("overflow", 64'(overflow), 64'(eov));
    check_eq("illegal", 64'(illegal), 64'(eill));
    if (hold > 0) begin
      inValid = 1'b1; opCode = 6'd0;
      repeat (hold) begin
        @(posedge clk); #1;
        check_eq("hold_out_valid", 64'(outValid), 64'd1);
        check_eq("hold_result", 64'(result), 64'(er));
        check_eq("hold_in_ready", 64'(inReady), 64'd0);
      end
      inValid = 1'b0;
    end
    @(negedge clk); outReady = 1'b1;
    @(posedge clk); #1; outReady = 1'b0;
    check_eq("out_valid_drop", 64'(outValid), 64'd0);
    check_eq("in_ready_after", 64'(inReady), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; inValid = 1'b1; outReady = 1'b0; inValid2 = 1'b0; outReady2 = 1'b0;
    opCode = 6'd0; operand1 = 32'h5; operand2 = 32'h6;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_out_valid", 64'(outValid), 64'd0);
    check_eq("reset_result", 64'(result), 64'd0);
    check_eq("reset_zero", 64'(zero), 64'd0);
    @(negedge clk); inValid = 1'b0; rst_n = 1'b1;
    #1 check_eq("reset_release_ready", 64'(inReady), 64'd1);

    run_op(6'd0, 32'hFFFF_FFFF, 32'h1, 0);
    run_op(6'd0, 32'h7FFF_FFFF, 32'h1, 0);
    run_op(6'd1, 32'h8000_0000, 32'h1, 0);
    run_op(6'd5, 32'h8000_0001, 32'd4, 0);
    run_op(6'd7, 32'h8000_0000, 32'd31, 0);
    run_op(6'd6, 32'h1234_5678, 32'hFFFF_FFE0, 0);
    run_op(6'd8, 32'h0001_0000, 32'h0001_0000, 0);
    run_op(6'd8, 32'd7, 32'd6, 0);
    run_op(6'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 10);
    run_op(6'h3F, 32'hDEAD_BEEF, 32'h1, 0);

    for (int i = 0; i < 40; i++) begin
      int unsigned r;
      logic [5:0]  op;
      logic [31:0] a, b;
      r  = $urandom_range(0, 9);
      op = (r == 9) ? 6'($urandom_range(9, 63)) : 6'(r);
      a  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 >> $urandom_range(0, 31) : $urandom;
      b  = $urandom;
      run_op(op, a, b, $urandom_range(0, 3));
    end

    // Reset mid-multiply after a nonzero result is registered.
    run_op(6'd0, 32'd5, 32'd3, 0);
    @(negedge clk);
    opCode = 6'd8; operand1 = 32'hFFFF; operand2 = 32'hFFFF; inValid = 1'b1;
    @(posedge clk); #1 inValid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midmul_reset_out_valid", 64'(outValid), 64'd0);
    check_eq("midmul_reset_result", 64'(result), 64'd0);
    check_eq("midmul_reset_ready", 64'(inReady), 64'd1);
    repeat (40) @(posedge clk);
    #1 check_eq("midmul_nothing_emitted", 64'(outValid), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op(6'd4, 32'hAAAA_5555, 32'hFFFF_0000, 0);

    // MUL_EN=0 build treats MUL as illegal.
    @(negedge clk);
    opCode = 6'd8; operand1 = 32'd7; operand2 = 32'd6; inValid2 = 1'b1;
    @(posedge clk); #1 inValid2 = 1'b0;
    check_eq("nomul_out_valid", 64'(outValid2), 64'd1);
    check_eq("nomul_illegal", 64'(illegal2), 64'd1);
    check_eq("nomul_result", 64'(result2), 64'd0);
    check_eq("nomul_zero", 64'(zero2), 64'd1);
    @(negedge clk); outReady2 = 1'b1;
    @(posedge clk); #1 outReady2 = 1'b0;
    check_eq("nomul_drop", 64'(outValid2), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
